// File: rtl/id_stage.sv
// id_stage: RV32I instruction-decode stage.
// Holds the 32x32 register file (x0 hard-wired to 0, write-through bypass
// from writeback), decodes InstrD into control signals and builds the
// sign-extended immediate. All outputs are combinational from InstrD and
// register state; they feed the ID/EX register directly.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   InstrD, PCD, PCPlus4D            IF/ID register contents
//   RegWriteW, RdW, ResultW          writeback write port
//   RegWriteD .. JumpD, ALUControlD,
//   ResultSrcD, IllegalD             decoded controls
//   RD1D, RD2D                       rs1/rs2 register reads
//   ImmExtD                          sign-extended immediate
//   InstrD_o, PCD_o, PCPlus4D_o      pass-throughs
//   RdD, Rs1D, Rs2D                  raw register fields
module id_stage #(
  parameter bit ZERO_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic        RegWriteD,
  output logic        MemWriteD,
  output logic        ALUSrcD,
  output logic        BranchD,
  output logic        JumpD,
  output logic [2:0]  ALUControlD,
  output logic [1:0]  ResultSrcD,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [31:0] ImmExtD,
  output logic [31:0] InstrD_o,
  output logic [31:0] PCD_o,
  output logic [31:0] PCPlus4D_o,
  output logic [4:0]  RdD,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        IllegalD
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NREGS = 32;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} imm_src_e;

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;
  logic [AW-1:0]   rs1, rs2;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7b5;
  imm_src_e        imm_src;

  assign opcode   = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7b5 = InstrD[30];
  assign rs1      = InstrD[19:15];
  assign rs2      = InstrD[24:20];

  // Writes to x0 and writes during reset are dropped; this also gates the bypass.
  assign wr_en = RegWriteW && (RdW != '0) && !reset;

  // Register file storage; reset clears every entry in one cycle when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (ZERO_ON_RESET) begin
        for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[RdW] <= ResultW;
    end
  end

  // Combinational reads with x0 forced to zero and writeback bypass.
  assign RD1D = (rs1 == '0) ? '0 :
                (wr_en && (RdW == rs1)) ? ResultW : regs[rs1];
  assign RD2D = (rs2 == '0) ? '0 :
                (wr_en && (RdW == rs2)) ? ResultW : regs[rs2];

  // Main decoder; an unsupported encoding squashes every control to 0.
  always_comb begin
    RegWriteD   = 1'b0;
    MemWriteD   = 1'b0;
    ALUSrcD     = 1'b0;
    BranchD     = 1'b0;
    JumpD       = 1'b0;
    ALUControlD = ALU_ADD;
    ResultSrcD  = RES_ALU;
    IllegalD    = 1'b0;
    imm_src     = IMM_NONE;
    case (opcode)
      OP_LW: begin
        imm_src    = IMM_I;
        RegWriteD  = 1'b1;
        ALUSrcD    = 1'b1;
        ResultSrcD = RES_MEM;
      end
      OP_SW: begin
        imm_src   = IMM_S;
        MemWriteD = 1'b1;
        ALUSrcD   = 1'b1;
      end
      OP_R: begin
        RegWriteD = 1'b1;
        case (funct3)
          3'b000:  ALUControlD = funct7b5 ? ALU_SUB : ALU_ADD;
          3'b111:  ALUControlD = ALU_AND;
          3'b110:  ALUControlD = ALU_OR;
          3'b010:  ALUControlD = ALU_SLT;
          default: IllegalD    = 1'b1;
        endcase
      end
      OP_I: begin
        imm_src   = IMM_I;
        RegWriteD = 1'b1;
        ALUSrcD   = 1'b1;
        case (funct3)
          3'b000:  ALUControlD = ALU_ADD;
          3'b111:  ALUControlD = ALU_AND;
          3'b110:  ALUControlD = ALU_OR;
          3'b010:  ALUControlD = ALU_SLT;
          default: IllegalD    = 1'b1;
        endcase
      end
      OP_BEQ: begin
        if (funct3 == 3'b000) begin
          imm_src     = IMM_B;
          BranchD     = 1'b1;
          ALUControlD = ALU_SUB;
        end else begin
          IllegalD = 1'b1;
        end
      end
      OP_JAL: begin
        imm_src    = IMM_J;
        JumpD      = 1'b1;
        RegWriteD  = 1'b1;
        ResultSrcD = RES_PC4;
      end
      default: IllegalD = 1'b1;
    endcase
    if (IllegalD) begin
      RegWriteD   = 1'b0;
      MemWriteD   = 1'b0;
      ALUSrcD     = 1'b0;
      BranchD     = 1'b0;
      JumpD       = 1'b0;
      ALUControlD = ALU_ADD;
      ResultSrcD  = RES_ALU;
      imm_src     = IMM_NONE;
    end
  end

  // Immediate generation, sign-extended from Instr[31].
  always_comb begin
    ImmExtD = '0;
    case (imm_src)
      IMM_I:   ImmExtD = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   ImmExtD = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   ImmExtD = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                          InstrD[11:8], 1'b0};
      IMM_J:   ImmExtD = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                          InstrD[30:21], 1'b0};
      default: ImmExtD = '0;
    endcase
  end

  assign InstrD_o   = InstrD;
  assign PCD_o      = PCD;
  assign PCPlus4D_o = PCPlus4D;
  assign RdD        = InstrD[11:7];
  assign Rs1D       = rs1;
  assign Rs2D       = rs2;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expectations are queued as each step is
// driven and popped/compared once the combinational outputs settle.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic        RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD, IllegalD;
  logic [2:0]  ALUControlD;
  logic [1:0]  ResultSrcD;
  logic [31:0] RD1D, RD2D, ImmExtD, InstrD_o, PCD_o, PCPlus4D_o;
  logic [4:0]  RdD, Rs1D, Rs2D;

  int checks   = 0;
  int failures = 0;

  id_stage dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
    .BranchD(BranchD), .JumpD(JumpD), .ALUControlD(ALUControlD),
    .ResultSrcD(ResultSrcD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .InstrD_o(InstrD_o), .PCD_o(PCD_o), .PCPlus4D_o(PCPlus4D_o),
    .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D), .IllegalD(IllegalD)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          c_ctrl;
    logic        rw, mw, as, br, jp, il;
    logic [2:0]  alu;
    logic [1:0]  rs;
    logic [31:0] imm;
    bit          c_rd1;
    logic [31:0] rd1;
    bit          c_rd2;
    logic [31:0] rd2;
    bit          c_fld;
    logic [4:0]  rd, r1, r2;
    logic [31:0] instr, pc;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t ex(input string tag);
    exp_t e;
    e = '{default: '0};
    e.tag = tag;
    return e;
  endfunction

  function automatic exp_t w_ctrl(input exp_t e, input logic rw, mw, as, br, jp, il,
                                  input logic [2:0] alu, input logic [1:0] rs,
                                  input logic [31:0] imm);
    e.c_ctrl = 1'b1;
    e.rw = rw; e.mw = mw; e.as = as; e.br = br; e.jp = jp; e.il = il;
    e.alu = alu; e.rs = rs; e.imm = imm;
    return e;
  endfunction

  function automatic exp_t w_rd(input exp_t e, input bit c1, input logic [31:0] v1,
                                input bit c2, input logic [31:0] v2);
    e.c_rd1 = c1; e.rd1 = v1; e.c_rd2 = c2; e.rd2 = v2;
    return e;
  endfunction

  function automatic exp_t w_fld(input exp_t e, input logic [4:0] rd, r1, r2);
    e.c_fld = 1'b1; e.rd = rd; e.r1 = r1; e.r2 = r2;
    return e;
  endfunction

  function automatic exp_t illegal(input string tag);
    return w_ctrl(ex(tag), 0, 0, 0, 0, 0, 1, 3'b000, 2'b00, 32'h0);
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] r2, r1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, r1, f3, rd, 7'b0010011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus at the negedge and queue its expectation.
  task automatic apply(input logic [31:0] instr, input logic rst, input logic we,
                       input logic [4:0] rd, input logic [31:0] data, input exp_t e);
    @(negedge clk);
    reset     = rst;
    InstrD    = instr;
    PCD       = $urandom;
    PCPlus4D  = PCD + 32'd4;
    RegWriteW = we;
    RdW       = rd;
    ResultW   = data;
    e.instr   = instr;
    e.pc      = PCD;
    sb.push_back(e);
    #2;
    compare();
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".instr_o"}, InstrD_o, e.instr);
    chk({e.tag, ".pc_o"}, PCD_o, e.pc);
    chk({e.tag, ".pc4_o"}, PCPlus4D_o, e.pc + 32'd4);
    if (e.c_ctrl) begin
      chk({e.tag, ".ctrl"},
          32'({RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD, IllegalD}),
          32'({e.rw, e.mw, e.as, e.br, e.jp, e.il}));
      chk({e.tag, ".alu"}, 32'(ALUControlD), 32'(e.alu));
      chk({e.tag, ".ressrc"}, 32'(ResultSrcD), 32'(e.rs));
      chk({e.tag, ".imm"}, ImmExtD, e.imm);
    end
    if (e.c_rd1) chk({e.tag, ".rd1"}, RD1D, e.rd1);
    if (e.c_rd2) chk({e.tag, ".rd2"}, RD2D, e.rd2);
    if (e.c_fld) begin
      chk({e.tag, ".rd"}, 32'(RdD), 32'(e.rd));
      chk({e.tag, ".rs1"}, 32'(Rs1D), 32'(e.r1));
      chk({e.tag, ".rs2"}, 32'(Rs2D), 32'(e.r2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; InstrD = '0; PCD = '0; PCPlus4D = 32'd4;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0;

    apply(32'h0, 1, 0, 0, 0, ex("reset0"));
    apply(32'h0, 1, 0, 0, 0, ex("reset1"));

    // Every register reads zero after reset.
    for (int i = 1; i < 32; i++)
      apply(r_type(7'h00, 5'(32 - i), 5'(i), 3'b000, 5'd1), 0, 0, 0, 0,
            w_rd(ex("rst_read"), 1, 32'h0, 1, 32'h0));

    apply(32'h0, 0, 0, 0, 0, w_fld(illegal("bubble"), 0, 0, 0));

    // Writeback bypass, then stored value.
    apply(r_type(7'h00, 5'd0, 5'd5, 3'b000, 5'd1), 0, 1, 5'd5, 32'hDEADBEEF,
          w_rd(ex("wb_bypass"), 1, 32'hDEADBEEF, 1, 32'h0));
    apply(r_type(7'h00, 5'd0, 5'd5, 3'b000, 5'd1), 0, 0, 5'd5, 32'h0,
          w_rd(ex("wb_stored"), 1, 32'hDEADBEEF, 1, 32'h0));
    apply(r_type(7'h00, 5'd6, 5'd5, 3'b000, 5'd1), 0, 1, 5'd6, 32'h0BADF00D,
          w_rd(ex("wb_bypass_rs2"), 1, 32'hDEADBEEF, 1, 32'h0BADF00D));

    // x0 is never written and always reads 0.
    apply(r_type(7'h00, 5'd0, 5'd0, 3'b000, 5'd1), 0, 1, 5'd0, 32'h1234,
          w_rd(ex("x0_during"), 1, 32'h0, 1, 32'h0));
    apply(r_type(7'h00, 5'd0, 5'd0, 3'b000, 5'd1), 0, 0, 5'd0, 32'h0,
          w_rd(ex("x0_after"), 1, 32'h0, 1, 32'h0));

    // Decode of each supported class.
    apply(32'hFFC4A303, 0, 0, 0, 0,
          w_fld(w_ctrl(ex("lw"), 1, 0, 1, 0, 0, 0, 3'b000, 2'b01, 32'hFFFFFFFC),
                5'd6, 5'd9, 5'd28));
    apply({7'b0000000, 5'd6, 5'd9, 3'b010, 5'b01000, 7'b0100011}, 0, 0, 0, 0,
          w_ctrl(ex("sw_pos"), 0, 1, 1, 0, 0, 0, 3'b000, 2'b00, 32'h8));
    apply({7'b1111111, 5'd6, 5'd9, 3'b010, 5'b11000, 7'b0100011}, 0, 0, 0, 0,
          w_ctrl(ex("sw_neg"), 0, 1, 1, 0, 0, 0, 3'b000, 2'b00, 32'hFFFFFFF8));
    apply(r_type(7'h00, 5'd6, 5'd5, 3'b000, 5'd7), 0, 0, 0, 0,
          w_ctrl(ex("add"), 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 32'h0));
    apply(r_type(7'h20, 5'd6, 5'd5, 3'b000, 5'd7), 0, 0, 0, 0,
          w_rd(w_ctrl(ex("sub"), 1, 0, 0, 0, 0, 0, 3'b001, 2'b00, 32'h0),
               1, 32'hDEADBEEF, 1, 32'h0BADF00D));
    apply(r_type(7'h00, 5'd6, 5'd5, 3'b111, 5'd7), 0, 0, 0, 0,
          w_ctrl(ex("and"), 1, 0, 0, 0, 0, 0, 3'b010, 2'b00, 32'h0));
    apply(r_type(7'h00, 5'd6, 5'd5, 3'b110, 5'd7), 0, 0, 0, 0,
          w_ctrl(ex("or"), 1, 0, 0, 0, 0, 0, 3'b011, 2'b00, 32'h0));
    apply(r_type(7'h00, 5'd6, 5'd5, 3'b010, 5'd7), 0, 0, 0, 0,
          w_ctrl(ex("slt"), 1, 0, 0, 0, 0, 0, 3'b101, 2'b00, 32'h0));
    apply(i_type(12'h400, 5'd5, 3'b000, 5'd3), 0, 0, 0, 0,
          w_ctrl(ex("addi_b30"), 1, 0, 1, 0, 0, 0, 3'b000, 2'b00, 32'h400));
    apply(i_type(12'hFFF, 5'd5, 3'b000, 5'd3), 0, 0, 0, 0,
          w_ctrl(ex("addi_m1"), 1, 0, 1, 0, 0, 0, 3'b000, 2'b00, 32'hFFFFFFFF));
    apply(i_type(12'h0F0, 5'd5, 3'b111, 5'd3), 0, 0, 0, 0,
          w_ctrl(ex("andi"), 1, 0, 1, 0, 0, 0, 3'b010, 2'b00, 32'hF0));
    apply(i_type(12'h7FF, 5'd5, 3'b110, 5'd3), 0, 0, 0, 0,
          w_ctrl(ex("ori"), 1, 0, 1, 0, 0, 0, 3'b011, 2'b00, 32'h7FF));
    apply(i_type(12'h800, 5'd5, 3'b010, 5'd3), 0, 0, 0, 0,
          w_ctrl(ex("slti"), 1, 0, 1, 0, 0, 0, 3'b101, 2'b00, 32'hFFFFF800));
    apply(32'h00628863, 0, 0, 0, 0,
          w_ctrl(ex("beq"), 0, 0, 0, 1, 0, 0, 3'b001, 2'b00, 32'h10));
    apply(32'h0080006F, 0, 0, 0, 0,
          w_ctrl(ex("jal"), 1, 0, 0, 0, 1, 0, 3'b000, 2'b10, 32'h8));

    // Unsupported encodings.
    apply(32'h4062D2B3, 0, 0, 0, 0, illegal("sra"));
    apply(i_type(12'h003, 5'd5, 3'b001, 5'd3), 0, 0, 0, 0, illegal("slli"));
    apply({7'b0, 5'd6, 5'd5, 3'b001, 5'b10000, 7'b1100011}, 0, 0, 0, 0, illegal("bne"));
    apply(32'h12345037, 0, 0, 0, 0, illegal("lui"));

    // Reset takes priority over a simultaneous write and disables the bypass.
    apply(r_type(7'h00, 5'd0, 5'd7, 3'b000, 5'd1), 0, 1, 5'd7, 32'h0000AAAA,
          w_rd(ex("x7_bypass"), 1, 32'h0000AAAA, 0, 32'h0));
    apply(r_type(7'h00, 5'd0, 5'd7, 3'b000, 5'd1), 0, 0, 5'd0, 32'h0,
          w_rd(ex("x7_stored"), 1, 32'h0000AAAA, 0, 32'h0));
    apply(r_type(7'h00, 5'd0, 5'd7, 3'b000, 5'd1), 1, 1, 5'd7, 32'h00005555,
          w_rd(ex("rst_nobypass"), 1, 32'h0000AAAA, 0, 32'h0));
    apply(r_type(7'h00, 5'd5, 5'd7, 3'b000, 5'd1), 0, 0, 5'd0, 32'h0,
          w_rd(ex("rst_wr_x7"), 1, 32'h0, 1, 32'h0));

    if (sb.size() != 0) chk("scoreboard_leftover", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage RV32I pipeline. It sits between the IF/ID pipeline register and the ID/EX pipeline register. It holds the 32×32 register file, decodes the instruction into control signals, and builds the sign-extended immediate. It accepts the writeback-stage write port and drives every D-suffixed input of the ID/EX register.

## Interface
- `ZERO_ON_RESET`, default 1: when 1, reset clears x1–x31; when 0, reset leaves register contents untouched.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  reset, synchronous, active-high
- `InstrD`  in  32  instruction from IF/ID
- `PCD`  in  32  PC of `InstrD`; passed through unchanged
- `PCPlus4D`  in  32  `PCD`+4; passed through unchanged
- `RegWriteW`  in  1  writeback write enable
- `RdW`  in  5  writeback destination register
- `ResultW`  in  32  writeback data
- `RegWriteD`, `MemWriteD`, `ALUSrcD`, `BranchD`, `JumpD`  out  1 each  decoded controls
- `ALUControlD`  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- `ResultSrcD`  out  2  result select: 00 ALU, 01 memory, 10 PC+4
- `RD1D`, `RD2D`  out  32  register reads of rs1 and rs2
- `ImmExtD`  out  32  sign-extended immediate
- `InstrD_o`  out  32  `InstrD` passed through
- `RdD`, `Rs1D`, `Rs2D`  out  5  raw fields `Instr[11:7]`, `[19:15]`, `[24:20]`
- `IllegalD`  out  1  unsupported encoding

## Operation
Register file:
- Holds x1–x31. x0 always reads 0 and is never written.
- Write on the rising edge when `RegWriteW` is 1, `RdW` ≠ 0, and `reset` is 0.
- Read is combinational, with write-through bypass: if `RegWriteW` is 1, `RdW` ≠ 0, `RdW` equals the read address, and `reset` is 0, the read returns `ResultW`.
- Reset with `ZERO_ON_RESET`=1 clears all registers in one cycle. Reset takes priority over a simultaneous write.

Decode (opcode = `Instr[6:0]`; encoding is given as ImmSrc, then the controls that are 1, then other fields; every control not named is 0):
- `0000011` lw: I-type immediate. RegWrite=1, ALUSrc=1. ResultSrc=01, ALUControl=add.
- `0100011` sw: S-type immediate. MemWrite=1, ALUSrc=1. ALUControl=add.
- `0110011` R-type: RegWrite=1, ALUSrc=0. ALUControl from funct3 and funct7[5]:
  - 000/0 → add
  - 000/1 → sub
  - 111 → and
  - 110 → or
  - 010 → slt
- `0010011` I-ALU: I-type immediate. RegWrite=1, ALUSrc=1. ALUControl from funct3:
  - 000 → add, regardless of `Instr[30]`
  - 111 → and
  - 110 → or
  - 010 → slt
- `1100011` beq (funct3 000 only): B-type immediate. Branch=1, ALUControl=sub.
- `1101111` jal: J-type immediate. Jump=1, RegWrite=1, ResultSrc=10.
- Any other opcode, or an unlisted funct3/funct7 combination: `IllegalD`=1, all controls 0, `ImmExtD`=0. `InstrD`=0 (a flushed bubble) therefore decodes as a harmless no-op.

Immediates, all sign-extended from `Instr[31]`:
- I: `[31:20]`
- S: `{[31:25],[11:7]}`
- B: `{[31],[7],[30:25],[11:8],0}`
- J: `{[31],[19:12],[20],[30:21],0}`

## Timing
- Decode, immediate and read paths are purely combinational from `InstrD` and register state. Latency to the ID/EX inputs is zero cycles.
- A writeback issued in cycle N is visible on `RD1D`/`RD2D` in cycle N via the bypass and stored at the end of cycle N. This resolves the WB→ID hazard without a stall.
- During reset, the bypass is disabled. With `ZERO_ON_RESET`=1, `RD1D`/`RD2D` read 0 from the first cycle after reset for every address.
- The block has no reset value on the pass-through outputs; they follow the inputs.
- A write to x0 is ignored. A simultaneous read of x0 returns 0 even while `RegWriteW`=1 and `RdW`=0.
- Rising edge with reset=1 and `RegWriteW`=1: no write occurs; all registers become 0.

## Test plan
- Reset, then read x1..x31 → all `RD1D`/`RD2D` = 0. Set `InstrD`=0 → `IllegalD`=1, all controls 0.
- `RegWriteW`=1, `RdW`=5, `ResultW`=0xDEADBEEF, with `InstrD` reading rs1=5 in the same cycle → `RD1D`=0xDEADBEEF that cycle and in the following cycle after write enable drops.
- Write 0x1234 to x0, then read x0 → `RD1D`=0 both during and after the write.
- `InstrD`=0xFFC4A303 (lw x6,-4(x9)) → `RegWriteD`=1, `ALUSrcD`=1, `ResultSrcD`=01, `ALUControlD`=000, `ImmExtD`=0xFFFFFFFC, `RdD`=6, `Rs1D`=9.
- `InstrD`=0x00628863 (beq x5,x6,+16) → `BranchD`=1, `ALUControlD`=001, `ImmExtD`=0x10. `InstrD`=0x0080006F (jal x0,+8) → `JumpD`=1, `ResultSrcD`=10, `ImmExtD`=8.
- `InstrD`=0x4062D2B3 (sra, unsupported) → `IllegalD`=1, all controls 0. Reset asserted together with a write to x7 → x7 reads 0 afterwards.
